// File: rtl/lvds_video_pkg.sv
// Shared types, grid defaults and helpers for the LVDS video backlight path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lvds_video_pkg;

  localparam int COLOR_W       = 8;

  localparam int ZONE_COLS_DEF = 24;
  localparam int ZONE_ROWS_DEF = 15;
  localparam int ZONE_W_DEF    = 80;
  localparam int ZONE_H_DEF    = 72;
  localparam int H_ACTIVE_DEF  = 1920;
  localparam int V_ACTIVE_DEF  = 1080;

  // Publish sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    PUBLISH
  } zone_state_t;

  // Flat index of a zone in the published vector.
  function automatic int zone_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

  // Unsigned maximum of two colour samples.
  function automatic logic [COLOR_W-1:0] max8(input logic [COLOR_W-1:0] a,
                                              input logic [COLOR_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zone_row_max.sv
// Running per-column peak luma for the zone row currently being scanned.
// Latency: an update is visible in colmax_dat one cycle after upd_vld.
// Backpressure: none; accepts one update per cycle, clr has priority over upd_vld.
module zone_row_max
  import lvds_video_pkg::*;
#(
  parameter int ZONE_COLS = ZONE_COLS_DEF,
  parameter int CIW       = $clog2(ZONE_COLS_DEF + 1)
) (
  input  logic                           I_clk,
  input  logic                           I_rst_n,
  input  logic                           upd_vld,
  input  logic [CIW-1:0]                 upd_col,
  input  logic [COLOR_W-1:0]             upd_lum,
  input  logic                           clr,
  output logic [ZONE_COLS*COLOR_W-1:0]   colmax_dat
);

  // Peak-hold per column; a clear wipes every column at once.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      colmax_dat <= '0;
    end else if (clr) begin
      colmax_dat <= '0;
    end else if (upd_vld) begin
      for (int c = 0; c < ZONE_COLS; c++) begin
        if (upd_col == CIW'(c)) begin
          colmax_dat[c*COLOR_W +: COLOR_W] <= max8(colmax_dat[c*COLOR_W +: COLOR_W], upd_lum);
        end
      end
    end
  end

endmodule

// File: rtl/video_zone_luma_extract.sv
// Per-zone peak max(R,G,B) over a frame, published as a flat double-buffered vector.
// Latency: O_frame_done rises 3 cycles after the DE-low cycle ending the last active line.
// Backpressure: none; the pixel stream is consumed every cycle, short frames are dropped.
module video_zone_luma_extract
  import lvds_video_pkg::*;
#(
  parameter int   H_ACTIVE  = H_ACTIVE_DEF,
  parameter int   V_ACTIVE  = V_ACTIVE_DEF,
  parameter int   ZONE_COLS = ZONE_COLS_DEF,
  parameter int   ZONE_ROWS = ZONE_ROWS_DEF,
  parameter int   ZONE_W    = ZONE_W_DEF,
  parameter int   ZONE_H    = ZONE_H_DEF,
  parameter logic VS_POL    = 1'b1
) (
  input  logic                                   I_pix_clk,
  input  logic                                   I_rst_n,
  input  logic                                   I_vs,
  input  logic                                   I_hs,
  input  logic                                   I_de,
  input  logic [COLOR_W-1:0]                     I_data_r,
  input  logic [COLOR_W-1:0]                     I_data_g,
  input  logic [COLOR_W-1:0]                     I_data_b,
  input  logic [COLOR_W-1:0]                     I_min_level,
  output logic [COLOR_W*ZONE_COLS*ZONE_ROWS-1:0] O_led_light,
  output logic                                   O_frame_done,
  output logic                                   O_frame_err
);

  localparam int CPW = $clog2(ZONE_W + 1);
  localparam int CIW = $clog2(ZONE_COLS + 1);
  localparam int RLW = $clog2(ZONE_H + 1);
  localparam int RIW = $clog2(ZONE_ROWS + 1);
  localparam int LNW = $clog2(V_ACTIVE + 1);

  localparam logic [CPW-1:0] COL_PX_LAST  = CPW'(ZONE_W - 1);
  localparam logic [CIW-1:0] COL_IDX_END  = CIW'(H_ACTIVE / ZONE_W);
  localparam logic [RLW-1:0] ROW_LN_LAST  = RLW'(ZONE_H - 1);
  localparam logic [RIW-1:0] ROW_IDX_LAST = RIW'(ZONE_ROWS - 1);
  localparam logic [LNW-1:0] LN_END       = LNW'(V_ACTIVE);

  // Lines are delimited by DE alone; HS carries no information here.
  logic unused_hs;
  assign unused_hs = I_hs;

  logic                 de_q, de_q2, vs_q, vs_q2;
  logic [COLOR_W-1:0]   lum_q;
  logic [CPW-1:0]       col_px;
  logic [CIW-1:0]       col_idx;
  logic [RLW-1:0]       row_ln;
  logic [RIW-1:0]       row_idx;
  logic [LNW-1:0]       ln_cnt;
  logic [COLOR_W*ZONE_COLS-1:0]           colmax;
  logic [COLOR_W*ZONE_COLS*ZONE_ROWS-1:0] work;
  zone_state_t          state_q, state_d;
  logic                 publish;

  logic frame_start, line_end, in_frame, accept_px, wb, wb_last, short_frame;

  // A VS edge overrides anything else happening in the same cycle.
  assign frame_start = (vs_q == VS_POL) && (vs_q2 != VS_POL);
  assign line_end    = de_q2 && !de_q;
  assign in_frame    = (ln_cnt != LN_END);
  assign accept_px   = de_q && in_frame && (col_idx != COL_IDX_END) && !frame_start;
  assign wb          = line_end && in_frame && (row_ln == ROW_LN_LAST) && !frame_start;
  assign wb_last     = wb && (row_idx == ROW_IDX_LAST);
  assign short_frame = frame_start && (ln_cnt != '0) && in_frame;

  // Stage 1: register sync/enable and reduce the pixel to its brightest channel.
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      de_q  <= 1'b0;
      de_q2 <= 1'b0;
      vs_q  <= ~VS_POL;
      vs_q2 <= ~VS_POL;
      lum_q <= '0;
    end else begin
      de_q  <= I_de;
      de_q2 <= de_q;
      vs_q  <= I_vs;
      vs_q2 <= vs_q;
      lum_q <= max8(max8(I_data_r, I_data_g), I_data_b);
    end
  end

  // Position counters: pixel within zone column, column, line within zone row, row, line.
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n || frame_start) begin
      col_px  <= '0;
      col_idx <= '0;
      row_ln  <= '0;
      row_idx <= '0;
      ln_cnt  <= '0;
    end else if (line_end) begin
      col_px  <= '0;
      col_idx <= '0;
      if (in_frame) begin
        ln_cnt <= ln_cnt + LNW'(1);
        if (row_ln == ROW_LN_LAST) begin
          row_ln  <= '0;
          row_idx <= row_idx + RIW'(1);
        end else begin
          row_ln <= row_ln + RLW'(1);
        end
      end
    end else if (accept_px) begin
      if (col_px == COL_PX_LAST) begin
        col_px  <= '0;
        col_idx <= col_idx + CIW'(1);
      end else begin
        col_px <= col_px + CPW'(1);
      end
    end
  end

  zone_row_max #(
    .ZONE_COLS (ZONE_COLS),
    .CIW       (CIW)
  ) u_row_max (
    .I_clk      (I_pix_clk),
    .I_rst_n    (I_rst_n),
    .upd_vld    (accept_px),
    .upd_col    (col_idx),
    .upd_lum    (lum_q),
    .clr        (frame_start || wb),
    .colmax_dat (colmax)
  );

  // Zone-row write-back into the working buffer, with the brightness floor applied.
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      work <= '0;
    end else if (wb) begin
      for (int r = 0; r < ZONE_ROWS; r++) begin
        if (row_idx == RIW'(r)) begin
          for (int c = 0; c < ZONE_COLS; c++) begin
            work[zone_idx(r, c, ZONE_COLS)*COLOR_W +: COLOR_W] <=
              max8(colmax[c*COLOR_W +: COLOR_W], I_min_level);
          end
        end
      end
    end
  end

  // Publish sequencer state register.
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the last zone-row write-back arms a one-cycle publish.
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (wb_last) begin
          state_d = PUBLISH;
        end else if (frame_start) begin
          state_d = IDLE;
        end else if (accept_px) begin
          state_d = ACCUM;
        end
      end
      PUBLISH: begin
        publish = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer and status pulses.
  always_ff @(posedge I_pix_clk) begin
    if (!I_rst_n) begin
      O_led_light  <= '0;
      O_frame_done <= 1'b0;
      O_frame_err  <= 1'b0;
    end else begin
      O_frame_done <= publish;
      O_frame_err  <= short_frame;
      if (publish) begin
        O_led_light <= work;
      end
    end
  end

endmodule
